// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: splits LB/LH/LW/LBU/LHU/SB/SH/SW accesses into
// single-byte bus transfers and returns extended load data to the register file.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        rf_wr_enable,
    output logic [4:0]  rf_wr_address,
    output logic [31:0] rf_wr_data
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMMIT
    } state_t;

    state_t            state;
    logic              op_store;
    logic [2:0]        op_funct3;
    logic [31:0]       op_data;
    logic [4:0]        op_rd;
    logic [1:0]        byte_idx;
    logic [1:0]        last_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       load_word;
    logic [31:0]       merged_word;

    function automatic logic legal_funct3(input logic store, input logic [2:0] f3);
        if (store)
            return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] last_byte(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] word);
        case (f3)
            3'b000:  return {{24{word[7]}}, word[7:0]};
            3'b001:  return {{16{word[15]}}, word[15:0]};
            3'b100:  return {24'h0, word[7:0]};
            3'b101:  return {16'h0, word[15:0]};
            default: return word;
        endcase
    endfunction

    // Load word including the byte being acknowledged this cycle.
    always_comb begin
        merged_word = load_word;
        merged_word[{byte_idx, 3'b000} +: 8] = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rf_wr_enable  <= 1'b0;
            rf_wr_address <= '0;
            rf_wr_data    <= '0;
            op_store      <= 1'b0;
            op_funct3     <= '0;
            op_data       <= '0;
            op_rd         <= '0;
            byte_idx      <= '0;
            last_idx      <= '0;
            wait_cnt      <= '0;
            load_word     <= '0;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            rf_wr_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_store  <= is_store;
                        op_funct3 <= funct3;
                        op_data   <= store_data;
                        op_rd     <= rd;
                        byte_idx  <= '0;
                        last_idx  <= last_byte(funct3);
                        wait_cnt  <= '0;
                        load_word <= '0;
                        busy      <= 1'b1;
                        if (!legal_funct3(is_store, funct3) || misaligned(funct3, address[1:0])) begin
                            state <= COMMIT;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= address;
                            mem_wdata <= store_data[7:0];
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        wait_cnt  <= '0;
                        load_word <= merged_word;
                        if (byte_idx == last_idx) begin
                            state   <= COMMIT;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            done    <= 1'b1;
                            if (!op_store && op_rd != 5'd0) begin
                                rf_wr_enable  <= 1'b1;
                                rf_wr_address <= op_rd;
                                rf_wr_data    <= extend_load(op_funct3, merged_word);
                            end
                        end else begin
                            // Next byte is presented on the very next cycle.
                            byte_idx  <= byte_idx + 2'd1;
                            mem_addr  <= mem_addr + 32'd1;
                            mem_wdata <= select_byte(op_data, byte_idx + 2'd1);
                        end
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        state   <= COMMIT;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// operations checked against a byte-array memory and arithmetic load/store model.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        busy, done, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        rf_wr_enable;
    logic [4:0]  rf_wr_address;
    logic [31:0] rf_wr_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [logic [31:0]];

    logic [31:0] q_addr[$];
    int          q_cyc[$];
    int          r_done_cyc;
    logic        r_err, r_we;
    logic [4:0]  r_ra;
    logic [31:0] r_data;
    bit          r_unstable, r_busy_bad;
    int          r_req_cycles;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
        .address(address), .store_data(store_data), .rd(rd), .busy(busy), .done(done),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_wr_enable(rf_wr_enable), .rf_wr_address(rf_wr_address), .rf_wr_data(rf_wr_data)
    );

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    function automatic int op_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit op_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 == 0 || f3 == 1 || f3 == 2)
                   : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1'b1;
        return (a % op_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v = 0;
        int n = op_size(f3);
        for (int k = 0; k < n; k++)
            v += longint'(rd_mem(a + 32'(k))) << (8 * k);
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // Drives one operation and plays the memory: acks each byte after 'delay' wait cycles.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] r, input int delay,
                          input int budget, input bit hold_start);
        int waited = 0;
        logic [31:0] pa = '0;
        logic [7:0] pw = '0;
        logic pwe = 1'b0;
        q_addr.delete(); q_cyc.delete();
        r_done_cyc = -1; r_err = 1'b0; r_we = 1'b0; r_ra = '0; r_data = '0;
        r_unstable = 0; r_busy_bad = 0; r_req_cycles = 0;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; address = a; store_data = sd; rd = r;
        mem_ack = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = hold_start;
            is_store = 1'($urandom); funct3 = 3'($urandom); address = $urandom;
            store_data = $urandom; rd = 5'($urandom);
            mem_ack = 1'b0; mem_rdata = 8'($urandom);
            if (done) begin
                r_done_cyc = cyc; r_err = err; r_we = rf_wr_enable;
                r_ra = rf_wr_address; r_data = rf_wr_data;
                break;
            end
            if (!busy) r_busy_bad = 1;
            if (mem_req) begin
                r_req_cycles++;
                if (waited > 0 && (mem_addr !== pa || mem_wdata !== pw || mem_we !== pwe))
                    r_unstable = 1;
                pa = mem_addr; pw = mem_wdata; pwe = mem_we;
                if (waited >= delay) begin
                    mem_ack = 1'b1;
                    q_addr.push_back(mem_addr);
                    q_cyc.push_back(cyc);
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = rd_mem(mem_addr);
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, mem_req, mem_we, rf_wr_enable} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, done, err, mem_req, mem_we, rf_wr_enable});
        end
        checks++;
        if ({mem_addr, mem_wdata, rf_wr_address, rf_wr_data} !== 77'b0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h ra=%h rdata=%h want zeros",
                     mem_addr, mem_wdata, rf_wr_address, rf_wr_data);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b want=0", busy);
        end
    endtask

    task automatic test_lw_directed();
        mem[32'h10] = 8'hAB; mem[32'h11] = 8'hEF; mem[32'h12] = 8'hCD; mem[32'h13] = 8'hAB;
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0, 40, 0);
        checks++;
        if (q_addr.size() != 4 || q_addr[0] !== 32'h10 || q_addr[1] !== 32'h11 ||
            q_addr[2] !== 32'h12 || q_addr[3] !== 32'h13) begin
            failures++;
            $display("FAIL lw_addrs got=%p want=10,11,12,13", q_addr);
        end
        checks++;
        if (q_cyc.size() != 4 || q_cyc[0] != 1 || q_cyc[3] != 4) begin
            failures++;
            $display("FAIL lw_consecutive cycles=%p want=1,2,3,4", q_cyc);
        end
        checks++;
        if (r_done_cyc != 5) begin
            failures++;
            $display("FAIL lw_latency got=%0d want=5", r_done_cyc);
        end
        checks++;
        if ({r_err, r_we, r_ra} !== {1'b0, 1'b1, 5'd5} || r_data !== 32'hABCDEFAB) begin
            failures++;
            $display("FAIL lw_result err=%b we=%b ra=%0d data=%h want 0 1 5 abcdefab",
                     r_err, r_we, r_ra, r_data);
        end
    endtask

    task automatic test_lb_lbu();
        mem[32'h21] = 8'hFA;
        run_op(1'b0, 3'b000, 32'h21, 32'h0, 5'd3, 0, 20, 0);
        checks++;
        if (r_done_cyc != 2 || r_we !== 1'b1 || r_data !== 32'hFFFFFFFA) begin
            failures++;
            $display("FAIL lb_sext cyc=%0d we=%b data=%h want 2 1 fffffffa", r_done_cyc, r_we, r_data);
        end
        run_op(1'b0, 3'b100, 32'h21, 32'h0, 5'd3, 0, 20, 0);
        checks++;
        if (r_we !== 1'b1 || r_data !== 32'h000000FA) begin
            failures++;
            $display("FAIL lbu_zext we=%b data=%h want 1 000000fa", r_we, r_data);
        end
    endtask

    task automatic test_sh_delay();
        mem[32'h40] = 8'h00; mem[32'h41] = 8'h00; mem[32'h42] = 8'h5A;
        run_op(1'b1, 3'b001, 32'h40, 32'h1234BEEF, 5'd9, 3, 40, 0);
        checks++;
        if (mem[32'h40] !== 8'hEF || mem[32'h41] !== 8'hBE || mem[32'h42] !== 8'h5A) begin
            failures++;
            $display("FAIL sh_bytes got=%h %h %h want ef be 5a", mem[32'h40], mem[32'h41], mem[32'h42]);
        end
        checks++;
        if (r_unstable || r_busy_bad) begin
            failures++;
            $display("FAIL sh_stable unstable=%0d busy_bad=%0d want 0 0", r_unstable, r_busy_bad);
        end
        checks++;
        if (r_done_cyc != 9 || r_err !== 1'b0 || r_we !== 1'b0) begin
            failures++;
            $display("FAIL sh_done cyc=%0d err=%b we=%b want 9 0 0", r_done_cyc, r_err, r_we);
        end
    endtask

    task automatic test_errors();
        logic [31:0] ea [4] = '{32'h2, 32'h8, 32'h31, 32'h50};
        logic [2:0]  ef [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
        logic        es [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(es[i], ef[i], ea[i], 32'hFFFF_FFFF, 5'd4, 0, 20, 0);
            checks++;
            if (r_done_cyc != 1 || r_err !== 1'b1 || r_we !== 1'b0 || r_req_cycles != 0) begin
                failures++;
                $display("FAIL start_error[%0d] cyc=%0d err=%b we=%b req=%0d want 1 1 0 0",
                         i, r_done_cyc, r_err, r_we, r_req_cycles);
            end
        end
    endtask

    task automatic test_timeout();
        run_op(1'b0, 3'b001, 32'h60, 32'h0, 5'd6, 1000, 40, 0);
        checks++;
        if (r_req_cycles != TIMEOUT || r_done_cyc != TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_len req=%0d done=%0d want %0d %0d",
                     r_req_cycles, r_done_cyc, TIMEOUT, TIMEOUT + 1);
        end
        checks++;
        if (r_err !== 1'b1 || r_we !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err err=%b we=%b want 1 0", r_err, r_we);
        end
    endtask

    task automatic test_start_while_busy();
        mem[32'h80] = 8'h11; mem[32'h81] = 8'h22;
        run_op(1'b0, 3'b101, 32'h80, 32'h0, 5'd12, 1, 20, 1);
        checks++;
        if (r_done_cyc != 5 || r_data !== 32'h00002211 || r_ra !== 5'd12) begin
            failures++;
            $display("FAIL busy_start cyc=%0d data=%h ra=%0d want 5 00002211 12", r_done_cyc, r_data, r_ra);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_idle busy=%b req=%b want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_reset_mid();
        bit saw = 0;
        mem[32'h100] = 8'h01; mem[32'h101] = 8'h82; mem[32'h102] = 8'h03; mem[32'h103] = 8'h84;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; address = 32'h100; rd = 5'd7;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0; mem_ack = 1'b1; mem_rdata = rd_mem(mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h102) begin
            failures++;
            $display("FAIL mid_pre req=%b addr=%h want 1 00000102", mem_req, mem_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset req=%b busy=%b want 0 0", mem_req, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || rf_wr_enable || busy) saw = 1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL mid_no_done activity=%0d want 0", saw);
        end
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 0, 20, 0);
        checks++;
        if (r_done_cyc != 5 || r_we !== 1'b1 || r_data !== 32'h84038201) begin
            failures++;
            $display("FAIL mid_after cyc=%0d we=%b data=%h want 5 1 84038201", r_done_cyc, r_we, r_data);
        end
        run_op(1'b0, 3'b000, 32'h101, 32'h0, 5'd0, 0, 20, 0);
        checks++;
        if (r_done_cyc != 2 || r_err !== 1'b0 || r_we !== 1'b0) begin
            failures++;
            $display("FAIL lb_rd0 cyc=%0d err=%b we=%b want 2 0 0", r_done_cyc, r_err, r_we);
        end
    endtask

    task automatic test_random();
        logic [2:0] legal_ld [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int t = 0; t < 60; t++) begin
            logic st;
            logic [2:0] f3;
            logic [31:0] a, sd, exp_val;
            logic [4:0] r;
            int dly, n, exp_cyc;
            bit bad;
            st = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom)
                 : (st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)]);
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) a = a & ~32'(op_size(f3) - 1);
            sd = $urandom; r = 5'($urandom); dly = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) mem[a + 32'(k)] = 8'($urandom);
            n = op_size(f3);
            bad = op_bad(st, f3, a);
            exp_val = model_load(f3, a);
            exp_cyc = bad ? 1 : n * (dly + 1) + 1;
            run_op(st, f3, a, sd, r, dly, 60, 0);
            checks++;
            if (r_done_cyc != exp_cyc || r_err !== 1'(bad)) begin
                failures++;
                $display("FAIL rnd_done[%0d] cyc=%0d err=%b want %0d %b", t, r_done_cyc, r_err, exp_cyc, bad);
            end
            checks++;
            if (r_we !== 1'(!bad && !st && r != 0) ||
                (r_we && (r_ra !== r || r_data !== exp_val))) begin
                failures++;
                $display("FAIL rnd_rf[%0d] we=%b ra=%0d data=%h want ra=%0d data=%h",
                         t, r_we, r_ra, r_data, r, exp_val);
            end
            checks++;
            if (q_addr.size() != (bad ? 0 : n) || r_unstable) begin
                failures++;
                $display("FAIL rnd_bus[%0d] bytes=%0d unstable=%0d want %0d 0",
                         t, q_addr.size(), r_unstable, bad ? 0 : n);
            end else begin
                for (int k = 0; k < q_addr.size(); k++) begin
                    checks++;
                    if (q_addr[k] !== a + 32'(k) ||
                        (st && rd_mem(a + 32'(k)) !== sd[8 * k +: 8])) begin
                        failures++;
                        $display("FAIL rnd_byte[%0d.%0d] addr=%h mem=%h want %h %h",
                                 t, k, q_addr[k], rd_mem(a + 32'(k)), a + 32'(k), sd[8 * k +: 8]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_directed();
        test_lb_lbu();
        test_sh_delay();
        test_errors();
        test_timeout();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
